// File: rtl/gen_stim_mc.sv
// gen_stim_mc: multi-channel biphasic stimulus train generator; config handshake (CFG_*), channel mask, sample strobe (DO_SAMPLE), status (BUSY/DONE), registered VSTIM_P/VSTIM_N drives.
module gen_stim_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 20,
  parameter int PRESC_W = 4,
  parameter int CH_OFFSET = 0
) (
  input  logic               CLK_500K,
  input  logic               RST_N,
  input  logic               ENABLE,
  input  logic               CFG_VALID,
  output logic               CFG_READY,
  input  logic [CNT_W-1:0]   CFG_WIDTH,
  input  logic [CNT_W-1:0]   CFG_GAP,
  input  logic [CNT_W-1:0]   CFG_PERIOD,
  input  logic               CFG_POL,
  input  logic [7:0]         CFG_BURST,
  output logic               CFG_ERR,
  input  logic [NUM_CH-1:0]  CH_MASK,
  input  logic [PRESC_W-1:0] MEASURE_PRESCALAR,
  output logic [NUM_CH-1:0]  VSTIM_P,
  output logic [NUM_CH-1:0]  VSTIM_N,
  output logic               DO_SAMPLE,
  output logic               BUSY,
  output logic               DONE
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  localparam int XW = CNT_W + 3;
  localparam logic [XW-1:0] SPAN = XW'((NUM_CH - 1) * CH_OFFSET);
  logic [1:0] state, nxt;
  logic [CNT_W-1:0] c, a_w, a_g, a_p, s_w, s_g, s_p;
  logic a_pol, s_pol, a_valid, s_valid, hold;
  logic [7:0] a_burst, s_burst, bcnt;
  logic [NUM_CH-1:0] mask_q, p_d, n_d;
  logic [PRESC_W-1:0] pc, presc_q, eff_presc, eff_cnt;
  logic running, wrap, last, bad, take, start, load, win_start, in_win, hit;
  logic [XW-1:0] thr;
  assign CFG_READY = !s_valid;
  assign BUSY = state != IDLE;
  assign running = BUSY;
  assign bad = CFG_WIDTH == '0 || XW'(CFG_PERIOD) < (XW'(CFG_WIDTH) << 1) + XW'(CFG_GAP) + SPAN;
  assign take = CFG_VALID && !s_valid && !bad;
  assign start = state == IDLE && ENABLE && !hold && (a_valid || s_valid);
  assign wrap = running && c == a_p - 1'b1;
  assign last = wrap && a_burst != '0 && bcnt == a_burst - 8'd1;
  assign load = start || wrap;
  assign thr = (XW'(a_w) << 1) + XW'(a_g) + SPAN;
  assign win_start = running && XW'(c) == thr;
  assign in_win = running && XW'(c) >= thr;
  // the prescaler value is captured only at window start, so mid-window changes wait a period
  assign eff_presc = win_start ? MEASURE_PRESCALAR : presc_q;
  assign eff_cnt = win_start ? '0 : pc;
  assign hit = in_win && eff_presc != '0 && eff_cnt == eff_presc - 1'b1;
  // DRAIN keeps running to the wrap; re-asserted ENABLE resumes RUN there
  always_comb
    nxt = start ? RUN : !running ? IDLE : wrap ? ((last || !ENABLE) ? IDLE : RUN) : ENABLE ? state : DRAIN;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [XW-1:0] off = XW'(k * CH_OFFSET);
    logic [XW-1:0] t;
    logic first, second;
    assign t = XW'(c) - off;
    assign first = XW'(c) >= off && t < XW'(a_w);
    assign second = XW'(c) >= off && t >= XW'(a_w) + XW'(a_g) && t < (XW'(a_w) << 1) + XW'(a_g);
    assign p_d[k] = running && mask_q[k] && (a_pol ? second : first);
    assign n_d[k] = running && mask_q[k] && (a_pol ? first : second);
  end
  always_ff @(posedge CLK_500K or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      c <= '0;
      bcnt <= '0;
      mask_q <= '0;
      {a_w, a_g, a_p, a_pol, a_burst, a_valid} <= '0;
      {s_w, s_g, s_p, s_pol, s_burst, s_valid} <= '0;
      hold <= 1'b0;
      CFG_ERR <= 1'b0;
      DONE <= 1'b0;
      VSTIM_P <= '0;
      VSTIM_N <= '0;
      DO_SAMPLE <= 1'b0;
      pc <= '0;
      presc_q <= '0;
    end else begin
      state <= nxt;
      c <= (!running || wrap) ? '0 : c + 1'b1;
      bcnt <= start ? '0 : wrap ? bcnt + 8'd1 : bcnt;
      if (load) mask_q <= CH_MASK;
      if (load && s_valid) begin
        {a_w, a_g, a_p, a_pol, a_burst} <= {s_w, s_g, s_p, s_pol, s_burst};
        a_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (take) begin
        {s_w, s_g, s_p, s_pol, s_burst} <= {CFG_WIDTH, CFG_GAP, CFG_PERIOD, CFG_POL, CFG_BURST};
        s_valid <= 1'b1;
      end
      CFG_ERR <= CFG_VALID && !s_valid && bad;
      hold <= last ? 1'b1 : ENABLE ? hold : 1'b0;
      DONE <= last;
      VSTIM_P <= p_d;
      VSTIM_N <= n_d;
      DO_SAMPLE <= hit;
      pc <= hit ? '0 : eff_cnt + 1'b1;
      presc_q <= eff_presc;
    end
endmodule
